// File: rtl/mod7_seek_ctrl.sv
// Purpose: seek sequencer that drives dir/now of a mod-7 up/down counter on
//          behalf of two round-robin requesters, taking the shorter direction.
// Latency: done 2 cycles after handshake for 0 ticks / invalid target,
//          otherwise 3*k-style spacing: ticks every GAP_CYCLES+1 cycles, done
//          one cycle after the last tick.
// Backpressure: req_ready is only offered in IDLE; requests hold until granted.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   req_valid[1:0]        per-requester seek request
//   req_target[5:0]       {target1, target0}, 3 bits each (7 = invalid)
//   req_ready[1:0]        one-hot grant, combinational in IDLE
//   value[2:0]            counter position, sampled only in PLAN
//   dir, now              counter direction (1 = up) and tick enable
//   busy                  high whenever not IDLE
//   done, done_id, done_err  one-cycle completion report
module mod7_seek_ctrl #(
  parameter int GAP_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_valid,
  input  logic [5:0] req_target,
  output logic [1:0] req_ready,
  input  logic [2:0] value,
  output logic       dir,
  output logic       now,
  output logic       busy,
  output logic       done,
  output logic       done_id,
  output logic       done_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PLAN,
    S_STEP,
    S_WAIT,
    S_DONE
  } state_t;

  // WAIT counts down from GAP_CYCLES-1 to 0, so it lasts GAP_CYCLES cycles.
  localparam logic [3:0] GAP_LAST = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

  state_t     state_q, state_d;
  logic [2:0] target_q, target_d;
  logic       id_q, id_d;
  logic       err_q, err_d;
  logic       dir_q, dir_d;
  logic [1:0] rem_q, rem_d;
  logic [3:0] gap_q, gap_d;
  logic       rr_q, rr_d;      // requester preferred when both are valid

  logic       grant_vld;
  logic       grant_id;
  logic [3:0] d_up;

  // Arbitration: a lone requester always wins, a tie goes to rr_q.
  always_comb begin
    grant_vld = |req_valid;
    grant_id  = 1'b0;
    case (req_valid)
      2'b01:   grant_id = 1'b0;
      2'b10:   grant_id = 1'b1;
      2'b11:   grant_id = rr_q;
      default: grant_id = 1'b0;
    endcase
  end

  // Upward distance (target - value) mod 7; zero means already there.
  always_comb begin
    if (target_q >= value) begin
      d_up = {1'b0, target_q} - {1'b0, value};
    end else begin
      d_up = {1'b0, target_q} + 4'd7 - {1'b0, value};
    end
  end

  always_comb begin
    state_d   = state_q;
    target_d  = target_q;
    id_d      = id_q;
    err_d     = err_q;
    dir_d     = dir_q;
    rem_d     = rem_q;
    gap_d     = gap_q;
    rr_d      = rr_q;
    req_ready = 2'b00;

    case (state_q)
      S_IDLE: begin
        // Gated by rst_n so no grant is offered while reset is asserted.
        if (grant_vld && rst_n) begin
          req_ready = grant_id ? 2'b10 : 2'b01;
          target_d  = grant_id ? req_target[5:3] : req_target[2:0];
          id_d      = grant_id;
          rr_d      = ~grant_id;
          state_d   = S_PLAN;
        end
      end

      S_PLAN: begin
        err_d = 1'b0;
        if (target_q == 3'd7) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else if (d_up == 4'd0) begin
          state_d = S_DONE;
        end else if (d_up <= 4'd3) begin
          dir_d   = 1'b1;
          rem_d   = d_up[1:0];
          state_d = S_STEP;
        end else begin
          dir_d   = 1'b0;
          rem_d   = 2'(4'd7 - d_up);
          state_d = S_STEP;
        end
      end

      S_STEP: begin
        rem_d = rem_q - 2'd1;
        if (rem_q == 2'd1) begin
          state_d = S_DONE;
        end else if (GAP_CYCLES == 0) begin
          state_d = S_STEP;
        end else begin
          gap_d   = GAP_LAST;
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        if (gap_q == 4'd0) begin
          state_d = S_STEP;
        end else begin
          gap_d = gap_q - 4'd1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      target_q <= 3'd0;
      id_q     <= 1'b0;
      err_q    <= 1'b0;
      dir_q    <= 1'b0;
      rem_q    <= 2'd0;
      gap_q    <= 4'd0;
      rr_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      id_q     <= id_d;
      err_q    <= err_d;
      dir_q    <= dir_d;
      rem_q    <= rem_d;
      gap_q    <= gap_d;
      rr_q     <= rr_d;
    end
  end

  assign dir      = dir_q;
  assign now      = (state_q == S_STEP);
  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);
  // Completion fields are forced low outside the done pulse.
  assign done_id  = done & id_q;
  assign done_err = done & err_q;

endmodule

// File: tb/tb_mod7_seek_ctrl.sv
module tb_mod7_seek_ctrl;

  localparam int GAP = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] req_valid;
  logic [5:0] req_target;
  logic [1:0] req_ready;
  logic [2:0] value;
  logic       dir, now, busy, done, done_id, done_err;

  logic       cnt_clr;
  logic [2:0] cnt;
  int         cyc = 0;
  int         n_tests = 0;
  int         n_fail = 0;

  typedef struct { int cyc; int id; } grant_t;
  typedef struct { int cyc; int dir; int val; } tick_t;
  typedef struct { int cyc; int id; int err; int val; } done_t;

  grant_t gq[$];
  tick_t  tq[$];
  done_t  dq[$];
  grant_t g_pop;
  tick_t  t_pop;
  done_t  d_pop;

  mod7_seek_ctrl #(.GAP_CYCLES(GAP)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_target (req_target),
    .req_ready  (req_ready),
    .value      (value),
    .dir        (dir),
    .now        (now),
    .busy       (busy),
    .done       (done),
    .done_id    (done_id),
    .done_err   (done_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Mod-7 up/down counter driven by the DUT; it has its own clear so a
  // controller reset leaves the position untouched.
  always @(posedge clk) begin
    if (cnt_clr) cnt <= 3'd0;
    else if (now) begin
      if (dir) cnt <= (cnt == 3'd6) ? 3'd0 : cnt + 3'd1;
      else     cnt <= (cnt == 3'd0) ? 3'd6 : cnt - 3'd1;
    end
  end
  assign value = cnt;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compares every observed handshake, tick and done against the queues.
  always @(negedge clk) begin
    if (|(req_valid & req_ready)) begin
      if (gq.size() == 0) chk("unexpected_grant", 1, 0);
      else begin
        g_pop = gq.pop_front();
        chk("grant_cycle", cyc, g_pop.cyc);
        chk("grant_id", req_ready[1] ? 1 : 0, g_pop.id);
      end
    end
    if (busy) chk("ready_while_busy", int'(req_ready), 0);
    if (now) begin
      if (tq.size() == 0) chk("unexpected_tick", 1, 0);
      else begin
        t_pop = tq.pop_front();
        chk("tick_cycle", cyc, t_pop.cyc);
        chk("tick_dir", int'(dir), t_pop.dir);
        chk("tick_value", int'(value), t_pop.val);
      end
    end
    if (done) begin
      if (dq.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        d_pop = dq.pop_front();
        chk("done_cycle", cyc, d_pop.cyc);
        chk("done_id", int'(done_id), d_pop.id);
        chk("done_err", int'(done_err), d_pop.err);
        chk("done_value", int'(value), d_pop.val);
      end
    end
  end

  task automatic expect_grant(input int c, input int id);
    gq.push_back('{cyc: c, id: id});
  endtask

  task automatic expect_ticks(input int c, input int k, input int d, input int v0);
    int v;
    v = v0;
    for (int i = 0; i < k; i++) begin
      tq.push_back('{cyc: c + 2 + i * (GAP + 1), dir: d, val: v});
      v = d ? (v + 1) % 7 : (v + 6) % 7;
    end
  endtask

  task automatic expect_done(input int c, input int id, input int err, input int val);
    dq.push_back('{cyc: c, id: id, err: err, val: val});
  endtask

  task automatic issue(input int id, input logic [2:0] tgt, output int c);
    @(posedge clk);
    #1;
    if (id == 1) req_target[5:3] = tgt;
    else         req_target[2:0] = tgt;
    req_valid[id] = 1'b1;
    c = cyc;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("idle_timeout", 1, 0);
  endtask

  // One seek: expected grant, k ticks from v0, done with final value vend.
  task automatic seek(input int id, input logic [2:0] tgt, input int k, input int d,
                      input int err, input int v0, input int vend);
    int c;
    issue(id, tgt, c);
    expect_grant(c, id);
    expect_ticks(c, k, d, v0);
    expect_done((k == 0) ? c + 2 : c + 2 + (k - 1) * (GAP + 1) + 1, id, err, vend);
    @(posedge clk);
    #1 req_valid[id] = 1'b0;
    wait_idle();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    rst_n = 1'b0; req_valid = 2'b00; req_target = 6'd0; cnt_clr = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1; cnt_clr = 1'b0;

    // Reset/idle outputs
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("idle_outputs", int'({now, dir, busy, done, done_id, done_err, req_ready}), 0);
    end

    // 0 -> 3 up, 3 ticks
    seek(0, 3'd3, 3, 1, 0, 0, 3);
    // 3 -> 1: d_up=5, down 2 ticks
    seek(0, 3'd1, 2, 0, 0, 3, 1);
    // 1 -> 5: d_up=4, down 3 ticks through the wrap 1,0,6,5
    seek(0, 3'd5, 3, 0, 0, 1, 5);

    // 5 -> 5 via requester 1: no ticks, done at c+2, busy only c+1..c+2
    issue(1, 3'd5, c);
    expect_grant(c, 1);
    expect_done(c + 2, 1, 0, 5);
    @(negedge clk); chk("eq_busy_c", int'(busy), 0);
    @(posedge clk); #1 req_valid[1] = 1'b0;
    @(negedge clk); chk("eq_busy_c1", int'(busy), 1);
    @(negedge clk); chk("eq_busy_c2", int'(busy), 1);
    @(negedge clk); chk("eq_busy_c3", int'(busy), 0);

    // Invalid target 7: error, no ticks
    seek(1, 3'd7, 0, 0, 1, 5, 5);

    // Both held valid: grants alternate 0,1,0,1, each waiting for IDLE
    @(posedge clk);
    #1 req_target = {3'd5, 3'd6}; req_valid = 2'b11;
    c = cyc;
    for (int n = 0; n < 4; n++) begin
      if (n % 2 == 0) begin
        expect_grant(c + 4 * n, 0);
        expect_ticks(c + 4 * n, 1, 1, 5);
        expect_done(c + 4 * n + 3, 0, 0, 6);
      end else begin
        expect_grant(c + 4 * n, 1);
        expect_ticks(c + 4 * n, 1, 0, 6);
        expect_done(c + 4 * n + 3, 1, 0, 5);
      end
    end
    for (int i = 0; i < 40 && cyc < c + 14; i++) begin
      @(posedge clk);
      #1;
    end
    req_valid = 2'b00;
    wait_idle();

    // 5 -> 2 (down, 3 ticks) aborted by reset in the WAIT after tick one
    issue(0, 3'd2, c);
    expect_grant(c, 0);
    expect_ticks(c, 1, 0, 5);
    @(posedge clk); #1 req_valid[0] = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("abort_state_outputs", int'({now, dir, busy, done, req_ready}), 0);
    repeat (8) @(negedge clk);
    chk("abort_value_frozen", int'(value), 4);

    // Tie after reset goes to requester 0 even though 0 was granted last
    @(posedge clk);
    #1 req_target = {3'd0, 3'd4}; req_valid = 2'b11;
    c = cyc;
    expect_grant(c, 0);
    expect_done(c + 2, 0, 0, 4);
    @(posedge clk); #1 req_valid = 2'b00;
    wait_idle();

    repeat (5) @(negedge clk);
    chk("grants_left", gq.size(), 0);
    chk("ticks_left", tq.size(), 0);
    chk("dones_left", dq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
